app_line_echo: RTL and testbench

//  Application-side stage of the USB CDC design, running on the 2 MHz app clock domain.

---
 rtl/app_pkg.sv | 22 ++
 rtl/app_line_ram.sv | 22 ++
 rtl/app_line_echo.sv | 143 ++++++++++++++
 tb/tb_app_line_echo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/app_pkg.sv
// Shared types and ASCII constants for the CDC line-echo application stage.
package app_pkg;

    typedef enum logic [2:0] {
        S_RX,
        S_LOAD,
        S_TX,
        S_LF,
        S_DONE
    } state_t;

    localparam logic [7:0] CHR_CR   = 8'h0D;
    localparam logic [7:0] CHR_LF   = 8'h0A;
    localparam logic [7:0] CHR_A_LO = 8'h61;
    localparam logic [7:0] CHR_Z_LO = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= CHR_A_LO && c <= CHR_Z_LO) ? c - CASE_OFS : c;
    endfunction

endpackage

// File: rtl/app_line_ram.sv
// Line buffer: one write port, registered read port, no reset so it maps onto a block RAM.
module app_line_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/app_line_echo.sv
// Buffers host bytes until end-of-line, echoes the line back (LF after a terminator),
// and flags sleep after a stretch with no handshakes on either stream.
module app_line_echo
    import app_pkg::*;
#(
    parameter int         DEPTH       = 64,
    parameter int         IDLE_CYCLES = 2_000_000,
    parameter logic [7:0] EOL         = 8'h0D,
    parameter bit         UPPERCASE   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic       sleep_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(IDLE_CYCLES + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

    state_t        state, state_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic          term, term_nxt;
    logic          in_valid_nxt;
    logic [7:0]    in_data_nxt;
    logic [CW-1:0] idle_cnt;
    logic          out_fire, in_fire;
    logic [7:0]    wdata, rdata;

    assign out_fire = out_valid_i && out_ready_o;
    assign in_fire  = in_valid_o && in_ready_i;
    assign wdata    = UPPERCASE ? to_upper(out_data_i) : out_data_i;

    app_line_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk_i),
        .we    (out_fire),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .re    (state == S_LOAD),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        term_nxt     = term;
        in_valid_nxt = in_valid_o;
        in_data_nxt  = in_data_o;
        case (state)
            S_RX: begin
                if (out_fire) begin
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    // terminator test uses the raw byte, before case mapping
                    if (out_data_i == EOL) begin
                        term_nxt  = 1'b1;
                        state_nxt = S_LOAD;
                    end else if (wr_ptr == LAST) begin
                        term_nxt  = 1'b0;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: state_nxt = S_TX;
            S_TX: begin
                // first cycle in S_TX captures the RAM word; later cycles wait for the sink
                if (!in_valid_o) begin
                    in_valid_nxt = 1'b1;
                    in_data_nxt  = rdata;
                end else if (in_ready_i) begin
                    rd_ptr_nxt   = rd_ptr + 1'b1;
                    in_valid_nxt = 1'b0;
                    if (rd_ptr + 1'b1 == wr_ptr) begin
                        if (term) begin
                            in_valid_nxt = 1'b1;
                            in_data_nxt  = CHR_LF;
                            state_nxt    = S_LF;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LF: begin
                if (in_fire) begin
                    in_valid_nxt = 1'b0;
                    state_nxt    = S_DONE;
                end
            end
            S_DONE: begin
                wr_ptr_nxt = '0;
                rd_ptr_nxt = '0;
                term_nxt   = 1'b0;
                state_nxt  = S_RX;
            end
            default: state_nxt = S_RX;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_RX;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            term        <= 1'b0;
            out_ready_o <= 1'b0;
            in_valid_o  <= 1'b0;
            in_data_o   <= 8'h00;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            term        <= term_nxt;
            out_ready_o <= (state_nxt == S_RX);
            in_valid_o  <= in_valid_nxt;
            in_data_o   <= in_data_nxt;
        end
    end

    // sleep_o reflects the previous count, so it falls one edge after a handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
            sleep_o  <= 1'b0;
        end else begin
            if (out_fire || in_fire)    idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            sleep_o <= (idle_cnt == IDLE_MAX);
        end
    end

endmodule

// File: tb/tb_app_line_echo.sv
// Random line traffic against a queue-based model of the echo stream, idle timer and reset.
module tb_app_line_echo;

    localparam int         DEPTH = 64;
    localparam int         IDLE  = 16;
    localparam logic [7:0] EOL   = 8'h0D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] out_data = 8'h00;
    logic       out_valid = 1'b0;
    logic       out_ready_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready = 1'b0;
    logic       sleep_o;

    always #5 clk = ~clk;

    app_line_echo #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .EOL(EOL), .UPPERCASE(1'b1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready),
        .sleep_o     (sleep_o)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] up(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
    endfunction

    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];
    int  cyc = 0, eol_cyc = 0, age = 0, age_prev = 0, stall_left = 0;
    bit  rst_edge = 1'b1, wait_first = 1'b0, holding = 1'b0, rdy_all = 1'b1;
    logic [7:0] held = 8'h00;

    // a line ends on the terminator or when the buffer fills; the echo is the mapped line (+LF)
    task automatic model_accept(input logic [7:0] b);
        line_q.push_back(b);
        if (b == EOL || line_q.size() == DEPTH) begin
            foreach (line_q[i]) exp_q.push_back(up(line_q[i]));
            if (b == EOL) exp_q.push_back(8'h0A);
            line_q.delete();
            wait_first = 1'b1;
            eol_cyc    = cyc + 1;
        end
    endtask

    // monitor: runs 2ns after each falling edge and reasons about the edge just past / next
    initial begin
        bit hs_in, hs_out;
        forever begin
            @(negedge clk); #2;
            if (rst_edge) begin
                chk("rst_out_ready", out_ready_o, 0);
                chk("rst_in_valid", in_valid_o, 0);
                chk("rst_in_data", in_data_o, 0);
            end
            chk("sleep", sleep_o, (age_prev >= IDLE) ? 1 : 0);
            if (holding) begin
                chk("hold_valid", in_valid_o, 1);
                chk("hold_data", in_data_o, held);
            end
            if (wait_first && in_valid_o) begin
                chk("first_latency", cyc - eol_cyc, 2);
                wait_first = 1'b0;
            end
            if (exp_q.size() != 0) chk("no_overlap", out_ready_o, 0);
            else                   chk("idle_valid", in_valid_o, 0);

            if (stall_left > 0 && in_valid_o) begin
                in_ready = 1'b0;
                stall_left--;
            end else begin
                in_ready = rdy_all ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            hs_in    = in_valid_o && in_ready && !rst;
            hs_out   = out_valid && out_ready_o && !rst;
            holding  = in_valid_o && !in_ready && !rst;
            held     = in_data_o;
            rst_edge = rst;
            if (rst) begin
                line_q.delete();
                exp_q.delete();
                wait_first = 1'b0;
                age        = 0;
                age_prev   = 0;
            end else begin
                if (hs_in) begin
                    if (exp_q.size() == 0) chk("in_extra", in_data_o, 32'hFFFF_FFFF);
                    else                   chk("in_data", in_data_o, exp_q.pop_front());
                end
                if (hs_out) model_accept(out_data);
                age_prev = age;
                age      = (hs_in || hs_out) ? 0 : ((age > IDLE + 4) ? age : age + 1);
            end
            cyc++;
        end
    end

    // called at a falling edge; returns at the falling edge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        out_data  = b;
        out_valid = 1'b1;
        while (!out_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_timeout", n, 0);
        @(negedge clk);
        out_valid = 1'b0;
        out_data  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_valid_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", n, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        do begin
            b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom);
        end while (b == EOL);
        return b;
    endfunction

    initial begin
        int n;
        do_reset();
        // idle timeout, then wake on one accepted byte
        repeat (20) @(negedge clk);
        chk("sleep_set", sleep_o, 1);
        send_byte(8'h41);
        chk("sleep_hold_at_hs", sleep_o, 1);
        @(negedge clk);
        chk("sleep_drop", sleep_o, 0);
        // stalled sink while the first echo byte is pending
        stall_left = 5;
        send_byte(EOL);
        wait_drain();

        send_byte(8'h61); send_byte(8'h62); send_byte(EOL);
        wait_drain();
        send_byte(8'h68); send_byte(8'h69); send_byte(8'h21); send_byte(EOL);
        wait_drain();
        send_byte(EOL);
        wait_drain();
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i));
        wait_drain();
        chk("ready_after_trunc", out_ready_o, 1);
        for (int i = 0; i < DEPTH - 1; i++) send_byte(rnd_byte());
        send_byte(EOL);
        wait_drain();

        // reset in the middle of an echo
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(EOL);
        n = 0;
        while (!(in_valid_o && exp_q.size() <= 3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("mid_tx_timeout", n, 0);
        do_reset();
        @(negedge clk);
        send_byte(8'h5A); send_byte(EOL);
        wait_drain();

        // random lines, random sink back-pressure and source gaps
        rdy_all = 1'b0;
        for (int l = 0; l < 25; l++) begin
            int len = $urandom_range(0, 80);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(rnd_byte());
            end
            if ($urandom_range(0, 4) != 0) send_byte(EOL);
            if ($urandom_range(0, 3) == 0) wait_drain();
        end
        wait_drain();
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
